// File: rtl/pc_fetch_pkg.sv
// Shared constants and types for the RV32I instruction-fetch stage.
// Package riscv_fetch_pkg is imported by the fetch interface, the IF/ID
// register and the pc_fetch top.
package riscv_fetch_pkg;

  // addi x0, x0, 0 -- what the IF/ID register carries when it is a bubble.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Default word of an unprogrammed instruction memory.
  localparam logic [31:0] EMPTY_INSTR = 32'h0000_0000;

  // Default PC loaded on reset.
  localparam logic [7:0] DEFAULT_RESET_PC = 8'h00;

  // Fetch control state. HALT is only ever entered when FETCH_HALT_EN is defined.
  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_if.sv
// Signal bundle between the fetch stage, the instruction memory, the
// execute-stage redirect source and the decoder.
//
// Flow control has no valid/ready pair. stall is a level hold request that
// freezes the PC and IF/ID. redirect is a one-cycle pulse that replaces the
// PC with redirect_pc and overrides stall. id_valid marks whether IF/ID holds
// a real instruction or a bubble.
interface pc_fetch_if #(
  parameter int AW = 8
);
  import riscv_fetch_pkg::*;

  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rd;
  logic          stall;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic [31:0]   id_instr;
  logic [AW-1:0] id_pc;
  logic [AW-1:0] id_pc4;
  logic          id_valid;
  logic          halted;
  fetch_state_t  dbg_state;

  // Fetch stage side.
  modport master (
    output imem_addr, id_instr, id_pc, id_pc4, id_valid, halted, dbg_state,
    input  imem_rd, stall, redirect, redirect_pc
  );

  // Memory, pipeline control and decoder side.
  modport slave (
    input  imem_addr, id_instr, id_pc, id_pc4, id_valid, halted, dbg_state,
    output imem_rd, stall, redirect, redirect_pc
  );

endinterface

// File: rtl/pc_fetch_if_id_reg.sv
// IF/ID pipeline register. Priority inside the module is reset, then bubble,
// then load, then hold. A bubble clears the instruction to a NOP and drops
// id_valid, and it keeps id_pc/id_pc4.
module if_id_reg
  import riscv_fetch_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          bubble,
  input  logic [31:0]   instr_in,
  input  logic [AW-1:0] pc_in,
  input  logic [AW-1:0] pc4_in,
  output logic [31:0]   id_instr,
  output logic [AW-1:0] id_pc,
  output logic [AW-1:0] id_pc4,
  output logic          id_valid
);

  logic [31:0]   instr_d, instr_q;
  logic [AW-1:0] pc_d, pc_q;
  logic [AW-1:0] pc4_d, pc4_q;
  logic          valid_d, valid_q;

  // Next IF/ID contents: bubble beats load; otherwise hold.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (bubble) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (load) begin
      instr_d = instr_in;
      pc_d    = pc_in;
      pc4_d   = pc4_in;
      valid_d = 1'b1;
    end
  end

  // IF/ID storage with synchronous reset to an empty NOP slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign id_instr = instr_q;
  assign id_pc    = pc_q;
  assign id_pc4   = pc4_q;
  assign id_valid = valid_q;

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch stage: PC register, next-PC selection and the RUN/HALT
// controller, feeding the IF/ID register.
// Optional feature macro: FETCH_HALT_EN -- when defined, fetching the empty
// word 32'h0 in RUN stops fetch in HALT until a redirect or reset.
// Per-edge priority: rst > redirect > stall > halt detection > advance.
module pc_fetch
  import riscv_fetch_pkg::*;
#(
  parameter int            AW       = 8,
  parameter logic [AW-1:0] RESET_PC = AW'(DEFAULT_RESET_PC)
) (
  input logic          clk,
  input logic          rst,
  pc_fetch_if.master   bus
);

  localparam logic [AW-1:0] PC_STEP    = AW'(4);
  localparam logic [AW-1:0] ALIGN_MASK = ~AW'(3);

  logic [AW-1:0] pc_d, pc_q;
  logic [AW-1:0] pc_plus4;
  fetch_state_t  state_d, state_q;
  logic          ifid_load;
  logic          ifid_bubble;

  // Sequential successor, wrapping modulo 2^AW.
  assign pc_plus4 = pc_q + PC_STEP;

  // Next PC, next state and IF/ID control, in priority order.
  always_comb begin
    pc_d        = pc_q;
    state_d     = state_q;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    if (bus.redirect) begin
      // Low two bits of the target are dropped to force word alignment.
      pc_d        = bus.redirect_pc & ALIGN_MASK;
      ifid_bubble = 1'b1;
      state_d     = RUN;
    end else if (bus.stall) begin
      // Everything holds.
      pc_d = pc_q;
`ifdef FETCH_HALT_EN
    end else if (state_q == HALT) begin
      ifid_bubble = 1'b1;
    end else if (bus.imem_rd == EMPTY_INSTR) begin
      ifid_bubble = 1'b1;
      state_d     = HALT;
`endif
    end else begin
      ifid_load = 1'b1;
      pc_d      = pc_plus4;
    end
  end

  // PC and controller state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      state_q <= RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  if_id_reg #(
    .AW (AW)
  ) u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (ifid_load),
    .bubble   (ifid_bubble),
    .instr_in (bus.imem_rd),
    .pc_in    (pc_q),
    .pc4_in   (pc_plus4),
    .id_instr (bus.id_instr),
    .id_pc    (bus.id_pc),
    .id_pc4   (bus.id_pc4),
    .id_valid (bus.id_valid)
  );

  assign bus.imem_addr = pc_q;
  assign bus.dbg_state = state_q;
`ifdef FETCH_HALT_EN
  assign bus.halted = (state_q == HALT);
`else
  assign bus.halted = 1'b0;
`endif

endmodule
